// File: rtl/cv32e40px_prefetch_buffer_ng.sv
// Instruction prefetcher between the IF stage and the OBI instruction bus.
// Ports: clk/rst, fetch control (req_i, branch_i, branch_addr_i),
// IF side (fetch_ready_i, fetch_valid_o, fetch_rdata_o, fetch_err_o),
// OBI side (instr_req_o, instr_gnt_i, instr_addr_o, instr_rdata_i,
// instr_rvalid_i, instr_err_i), status (busy_o).

module cv32e40px_prefetch_buffer_ng #(
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned MAX_OUTST  = 2,
    parameter logic [31:0] RESET_ADDR = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_i,
    input  logic        branch_i,
    input  logic [31:0] branch_addr_i,
    input  logic        fetch_ready_i,
    output logic        fetch_valid_o,
    output logic [31:0] fetch_rdata_o,
    output logic        fetch_err_o,
    output logic        instr_req_o,
    input  logic        instr_gnt_i,
    output logic [31:0] instr_addr_o,
    input  logic [31:0] instr_rdata_i,
    input  logic        instr_rvalid_i,
    input  logic        instr_err_i,
    output logic        busy_o
);

    localparam int unsigned CW = $clog2(MAX_OUTST + 1);
    localparam int unsigned FW = $clog2(DEPTH + 1);
    localparam int unsigned AW = $clog2(DEPTH);

    typedef enum logic {
        IDLE,
        REQ
    } state_t;

    state_t        state_q;
    state_t        state_nxt;
    logic [31:0]   addr_q;
    logic [31:0]   addr_nxt;
    logic          br_pend_q;
    logic          br_pend_nxt;
    logic [31:0]   br_addr_q;
    logic [31:0]   br_addr_nxt;
    logic          drop_pend_q;
    logic          drop_pend_nxt;
    logic [CW-1:0] outst_q;
    logic [CW-1:0] outst_nxt;
    logic [CW-1:0] discard_q;
    logic [CW-1:0] discard_nxt;
    logic          halted_q;
    logic          halted_nxt;
    logic [FW-1:0] cnt_q;
    logic [FW-1:0] cnt_nxt;
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [32:0]   mem [DEPTH];

    logic          waiting;
    logic          gnt_fire;
    logic          kept;
    logic          push;
    logic          pop;
    logic          fifo_empty;
    logic          issue_nxt;
    logic [31:0]   credit;
    logic [31:0]   target;
    logic [32:0]   head;
    logic          unused_bits;

    assign unused_bits = ^branch_addr_i[1:0];
    assign target      = {branch_addr_i[31:2], 2'b00};

    // An ungranted request must stay frozen on the bus.
    assign waiting  = (state_q == REQ) && !instr_gnt_i;
    assign gnt_fire = (state_q == REQ) && instr_gnt_i;

    assign fifo_empty = (cnt_q == '0);
    assign head       = mem[rd_ptr_q];

    // Responses during a redirect belong to the old stream.
    assign kept = instr_rvalid_i && (discard_q == '0) && !branch_i;

    assign fetch_valid_o = !branch_i && (!fifo_empty || kept);
    assign pop  = fetch_valid_o && fetch_ready_i && !fifo_empty;
    // Fall-through consumes the response without touching the FIFO.
    assign push = kept && !(fifo_empty && fetch_ready_i);

    always_comb begin
        fetch_rdata_o = '0;
        fetch_err_o   = 1'b0;
        if (fetch_valid_o) begin
            if (!fifo_empty) begin
                fetch_rdata_o = head[31:0];
                fetch_err_o   = head[32];
            end else begin
                fetch_rdata_o = instr_rdata_i;
                fetch_err_o   = instr_err_i;
            end
        end
    end

    assign instr_req_o  = (state_q == REQ);
    assign instr_addr_o = addr_q;
    assign busy_o       = (outst_q != '0) || (state_q == REQ);

    always_comb begin
        outst_nxt = outst_q;
        if (gnt_fire && !instr_rvalid_i) begin
            outst_nxt = outst_q + CW'(1);
        end else if (!gnt_fire && instr_rvalid_i) begin
            outst_nxt = outst_q - CW'(1);
        end
    end

    // The drop flag of a pending request turns into a discard
    // credit once that request is actually granted.
    always_comb begin
        discard_nxt   = discard_q;
        drop_pend_nxt = drop_pend_q;
        if (instr_rvalid_i && (discard_q != '0)) begin
            discard_nxt = discard_nxt - CW'(1);
        end
        if (gnt_fire) begin
            drop_pend_nxt = 1'b0;
            if (drop_pend_q) begin
                discard_nxt = discard_nxt + CW'(1);
            end
        end
        if (branch_i) begin
            discard_nxt   = outst_nxt;
            drop_pend_nxt = waiting;
        end
    end

    always_comb begin
        cnt_nxt = cnt_q;
        if (branch_i) begin
            cnt_nxt = '0;
        end else if (push && !pop) begin
            cnt_nxt = cnt_q + FW'(1);
        end else if (!push && pop) begin
            cnt_nxt = cnt_q - FW'(1);
        end
    end

    always_comb begin
        halted_nxt = halted_q;
        if (branch_i) begin
            halted_nxt = 1'b0;
        end else if (kept && instr_err_i) begin
            halted_nxt = 1'b1;
        end
    end

    // Credit: responses still expected to land plus entries held.
    assign credit = 32'(outst_nxt) - 32'(discard_nxt) + 32'(cnt_nxt);

    assign issue_nxt = req_i && !halted_nxt &&
                       (32'(outst_nxt) < 32'(MAX_OUTST)) &&
                       (credit < 32'(DEPTH));

    always_comb begin
        state_nxt = IDLE;
        if (waiting || issue_nxt) begin
            state_nxt = REQ;
        end
    end

    always_comb begin
        addr_nxt    = addr_q;
        br_pend_nxt = br_pend_q;
        br_addr_nxt = br_addr_q;
        if (waiting) begin
            if (branch_i) begin
                br_pend_nxt = 1'b1;
                br_addr_nxt = target;
            end
        end else if (branch_i) begin
            addr_nxt    = target;
            br_pend_nxt = 1'b0;
        end else if (gnt_fire) begin
            addr_nxt    = br_pend_q ? br_addr_q : addr_q + 32'd4;
            br_pend_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            addr_q      <= RESET_ADDR;
            br_pend_q   <= 1'b0;
            br_addr_q   <= '0;
            drop_pend_q <= 1'b0;
            outst_q     <= '0;
            discard_q   <= '0;
            halted_q    <= 1'b0;
            cnt_q       <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
        end else begin
            state_q     <= state_nxt;
            addr_q      <= addr_nxt;
            br_pend_q   <= br_pend_nxt;
            br_addr_q   <= br_addr_nxt;
            drop_pend_q <= drop_pend_nxt;
            outst_q     <= outst_nxt;
            discard_q   <= discard_nxt;
            halted_q    <= halted_nxt;
            cnt_q       <= cnt_nxt;
            if (branch_i) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
            end else begin
                if (push) begin
                    wr_ptr_q <= wr_ptr_q + AW'(1);
                end
                if (pop) begin
                    rd_ptr_q <= rd_ptr_q + AW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= {instr_err_i, instr_rdata_i};
        end
    end

endmodule
